// File: rtl/video_output_stage_if.sv
// Pixel bundle for video_output_stage: raw timing and mixer RGB in, registered video out to the PHY.
// master = upstream driver/PHY side, slave = the output stage itself.
interface video_output_stage_if #(
  parameter int OUT_BITS = 8
);
  logic [3:0]          pc_ena_in;
  logic                hs_in;
  logic                vs_in;
  logic                hde_in;
  logic                vde_in;
  logic [7:0]          pixel_in_r;
  logic [7:0]          pixel_in_g;
  logic [7:0]          pixel_in_b;
  logic [OUT_BITS-1:0] vid_r;
  logic [OUT_BITS-1:0] vid_g;
  logic [OUT_BITS-1:0] vid_b;
  logic                vid_hs;
  logic                vid_vs;
  logic                vid_de;
  logic                frame_tick;

  modport master (
    output pc_ena_in, hs_in, vs_in, hde_in, vde_in, pixel_in_r, pixel_in_g, pixel_in_b,
    input  vid_r, vid_g, vid_b, vid_hs, vid_vs, vid_de, frame_tick
  );

  modport slave (
    input  pc_ena_in, hs_in, vs_in, hde_in, vde_in, pixel_in_r, pixel_in_g, pixel_in_b,
    output vid_r, vid_g, vid_b, vid_hs, vid_vs, vid_de, frame_tick
  );
endinterface

// File: rtl/video_output_stage.sv
// Final video pipeline stage: re-aligns raw timing to mixer RGB, blanks, reduces width, registers outputs.
// Define VIDEO_OUT_DITHER_EN for 4x4 ordered dither on width reduction (default build truncates).
module video_output_stage #(
  parameter int SYNC_DELAY = 2,
  parameter int OUT_BITS   = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  video_output_stage_if.slave vif
);

  localparam int DROP = 8 - OUT_BITS;

  typedef struct packed {
    logic hs;
    logic vs;
    logic hde;
    logic vde;
  } timing_t;

  logic    tick;
  timing_t dly [SYNC_DELAY];
  timing_t d;
  logic    d_de;

  assign tick = (vif.pc_ena_in == 4'h0);
  assign d    = dly[SYNC_DELAY-1];
  assign d_de = d.hde & d.vde;

  // NOTE: the delay line is a few flops rather than a RAM, so it is cleared on reset; that is what
  // keeps the outputs black after a mid-frame reset until real timing has propagated through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_DELAY; i++) dly[i] <= '0;
    end else if (tick) begin
      dly[0] <= timing_t'({vif.hs_in, vif.vs_in, vif.hde_in, vif.vde_in});
      for (int i = 1; i < SYNC_DELAY; i++) dly[i] <= dly[i-1];
    end
  end

`ifdef VIDEO_OUT_DITHER_EN
  localparam logic [3:0] BAYER [16] = '{4'd0,  4'd8,  4'd2,  4'd10,
                                        4'd12, 4'd4,  4'd14, 4'd6,
                                        4'd3,  4'd11, 4'd1,  4'd9,
                                        4'd15, 4'd7,  4'd13, 4'd5};

  logic [1:0] x;
  logic [1:0] y;
  logic       d_hde_q;
  logic [7:0] thr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x       <= '0;
      y       <= '0;
      d_hde_q <= 1'b0;
    end else if (tick) begin
      d_hde_q <= d.hde;
      x       <= d_de ? x + 2'd1 : 2'd0;
      // Vertical blanking clears y even on the tick that also ends a line.
      if (!d.vde)                 y <= '0;
      else if (d_hde_q && !d.hde) y <= y + 2'd1;
    end
  end

  if (DROP <= 4) begin : g_thr_down
    assign thr = 8'(BAYER[{y, x}] >> (4 - DROP));
  end else begin : g_thr_up
    assign thr = 8'(BAYER[{y, x}]) << (DROP - 4);
  end

  // NOTE: blocking assignments are correct here because s is a function-local temporary;
  // every register in this module is updated with <= only.
  function automatic logic [OUT_BITS-1:0] reduce(input logic [7:0] c);
    logic [8:0] s;
    s = {1'b0, c} + {1'b0, thr};
    if (s[8]) s = 9'h0FF;
    return s[7:DROP];
  endfunction
`else
  function automatic logic [OUT_BITS-1:0] reduce(input logic [7:0] c);
    return c[7:DROP];
  endfunction
`endif

  // vid_vs holds the previous d.vs, so its rising edge and frame_tick land together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vif.vid_hs     <= 1'b0;
      vif.vid_vs     <= 1'b0;
      vif.vid_de     <= 1'b0;
      vif.frame_tick <= 1'b0;
      vif.vid_r      <= '0;
      vif.vid_g      <= '0;
      vif.vid_b      <= '0;
    end else if (tick) begin
      vif.vid_hs     <= d.hs;
      vif.vid_vs     <= d.vs;
      vif.vid_de     <= d_de;
      vif.frame_tick <= d.vs & ~vif.vid_vs;
      vif.vid_r      <= d_de ? reduce(vif.pixel_in_r) : '0;
      vif.vid_g      <= d_de ? reduce(vif.pixel_in_g) : '0;
      vif.vid_b      <= d_de ? reduce(vif.pixel_in_b) : '0;
    end else begin
      vif.frame_tick <= 1'b0;
    end
  end

endmodule
